// File: rtl/pool_frame_ctrl.sv
// pool_frame_ctrl: frame sequencer, credit-gated upstream handshake and FWFT result FIFO for the 2x2 max-pool stage.
// Optional build macro POOL_CTRL_PERF_EN adds the stall_cycles performance counter output.
module pool_frame_ctrl #(
   parameter int unsigned IN_WIDTH   = 24,
   parameter int unsigned IN_HEIGHT  = 24,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         frame_done,
   input  logic         s_valid,
   output logic         s_ready,
   output logic         pool_valid_in,
   input  logic         pool_out_valid,
   input  logic [191:0] pool_out_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [191:0] m_data,
   output logic         overflow
`ifdef POOL_CTRL_PERF_EN
   ,
   output logic [31:0]  stall_cycles
`endif
);

   localparam int unsigned CW    = $clog2(IN_WIDTH);
   localparam int unsigned RW    = $clog2(IN_HEIGHT);
   localparam int unsigned TOTAL = (IN_WIDTH / 2) * (IN_HEIGHT / 2);
   localparam int unsigned PW    = $clog2(TOTAL + 1);
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned OW    = AW + 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IN_HEIGHT - 1);
   localparam logic [PW-1:0] POP_TOTAL = PW'(TOTAL);
   localparam logic [OW-1:0] DEPTH_OCC = OW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] popped_q, popped_d;
   logic          inflight_q, inflight_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic [191:0]  mem_q [FIFO_DEPTH];
   logic [191:0]  mem_d [FIFO_DEPTH];

   logic          producing, xfer, full, pop, push;
   logic [OW-1:0] credit;

   // A producing beat needs a FIFO slot reserved ahead of time: the pool cannot stall.
   assign producing     = row_q[0] & col_q[0];
   assign credit        = occ_q + OW'(inflight_q);
   assign s_ready       = (state_q == S_RUN) && (!producing || (credit < DEPTH_OCC));
   assign xfer          = s_valid & s_ready;
   assign pool_valid_in = xfer;

   assign full     = (occ_q == DEPTH_OCC);
   assign m_valid  = (occ_q != '0);
   assign pop      = m_valid & m_ready;
   assign push     = pool_out_valid & (!full | pop);
   assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
   assign overflow = overflow_q;

   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      popped_d = popped_q;
      if (xfer) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
      if (pop && (state_q == S_RUN || state_q == S_DRAIN)) popped_d = popped_q + PW'(1);
      case (state_q)
         S_IDLE: if (start) begin
            state_d  = S_RUN;
            col_d    = '0;
            row_d    = '0;
            popped_d = '0;
         end
         S_RUN:   if (xfer && col_q == COL_LAST && row_q == ROW_LAST) state_d = S_DRAIN;
         S_DRAIN: if (popped_d == POP_TOTAL) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (xfer && producing) inflight_d = 1'b1;
      else if (pool_out_valid) inflight_d = 1'b0;
      occ_d      = occ_q + OW'(push) - OW'(pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      overflow_d = overflow_q | (pool_out_valid & full & !pop);
      mem_d      = mem_q;
      if (push) mem_d[wr_ptr_q] = pool_out_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         popped_q   <= '0;
         inflight_q <= 1'b0;
         occ_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         popped_q   <= popped_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

`ifdef POOL_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (state_q == S_IDLE && start) stall_cycles_d = '0;
      else if (state_q == S_RUN && s_valid && !s_ready && stall_cycles_q != '1)
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cycles_q <= '0;
      else        stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Self-checking bench for pool_frame_ctrl: emulates the pool datapath and checks frames against 2x2 block maxima.
module tb_pool_frame_ctrl;
   localparam int W  = 24;
   localparam int H  = 24;
   localparam int D  = 4;
   localparam int NB = W * H;
   localparam int NR = (W / 2) * (H / 2);

   logic clk = 1'b0;
   logic rst_n, start, s_valid, m_ready;
   logic busy, frame_done, s_ready, pool_valid_in, m_valid, overflow;
   logic [191:0] m_data;
   logic         pool_out_valid;
   logic [191:0] pool_out_data;
   logic         model_pv = 1'b0, inj_pv = 1'b0;
   logic [191:0] model_data = '0, inj_data = '0;
`ifdef POOL_CTRL_PERF_EN
   logic [31:0]  stall_cycles;
`endif

   assign pool_out_valid = model_pv | inj_pv;
   assign pool_out_data  = inj_pv ? inj_data : model_data;

   pool_frame_ctrl #(.IN_WIDTH(W), .IN_HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
      .s_valid(s_valid), .s_ready(s_ready), .pool_valid_in(pool_valid_in),
      .pool_out_valid(pool_out_valid), .pool_out_data(pool_out_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .overflow(overflow)
`ifdef POOL_CTRL_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Frame contents: two slots so back-to-back frames can differ.
   int           pix [2][NB][6];
   logic [191:0] exp_res [2][NR];

   task automatic gen_frame(input int s);
      logic [191:0] v;
      int m, b0;
      for (int k = 0; k < NB; k++)
         for (int ch = 0; ch < 6; ch++) pix[s][k][ch] = int'($urandom);
      for (int b = 0; b < NR; b++) begin
         b0 = (b / (W / 2)) * 2 * W + (b % (W / 2)) * 2;
         for (int ch = 0; ch < 6; ch++) begin
            m = pix[s][b0][ch];
            if (pix[s][b0 + 1][ch] > m)     m = pix[s][b0 + 1][ch];
            if (pix[s][b0 + W][ch] > m)     m = pix[s][b0 + W][ch];
            if (pix[s][b0 + W + 1][ch] > m) m = pix[s][b0 + W + 1][ch];
            v[ch*32 +: 32] = m;
         end
         exp_res[s][b] = v;
      end
   endtask

   function automatic logic [191:0] rand192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Pool emulation: registered, one-cycle latency, own raster counters.
   int   emu_cnt = 0;
   int   e_pos, e_r, e_c;
   logic pv_s, rs_s;
   always begin
      @(negedge clk);
      pv_s = pool_valid_in;
      rs_s = rst_n;
      @(posedge clk);
      #1;
      if (!rs_s) begin
         emu_cnt  = 0;
         model_pv = 1'b0;
      end else if (pv_s) begin
         e_pos = emu_cnt % NB;
         e_r   = e_pos / W;
         e_c   = e_pos % W;
         if (e_r % 2 == 1 && e_c % 2 == 1) begin
            model_pv   = 1'b1;
            model_data = exp_res[(emu_cnt / NB) % 2][(e_r / 2) * (W / 2) + e_c / 2];
         end else begin
            model_pv = 1'b0;
         end
         emu_cnt++;
      end else begin
         model_pv = 1'b0;
      end
   end

   // Observation recorder (no checking here).
   int cyc = 0;
   int beats, fbeats, fd_cnt, fd_cyc, last_beat_cyc, stalls, np_stalls, first_stall;
   int first_prod_cyc, first_pop_cyc, hold_err;
   logic [191:0] got_q [$];
   logic         prev_hold = 1'b0;
   logic [191:0] prev_data = '0;
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         fbeats    = 0;
         prev_hold = 1'b0;
      end else begin
         if (busy && s_valid && !s_ready && fbeats < NB) begin
            stalls++;
            if (first_stall < 0) first_stall = fbeats;
            if (!((fbeats / W) % 2 == 1 && (fbeats % W) % 2 == 1)) np_stalls++;
         end
         if (pool_valid_in) begin
            if (first_prod_cyc < 0 && (fbeats / W) % 2 == 1 && (fbeats % W) % 2 == 1)
               first_prod_cyc = cyc;
            beats++;
            fbeats++;
            last_beat_cyc = cyc;
         end
         if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
         end
         if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data)) hold_err++;
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            fbeats = 0;
         end
      end
   end

   task automatic clear_mon();
      got_q.delete();
      beats = 0; fbeats = 0; fd_cnt = 0; fd_cyc = -1; last_beat_cyc = -1;
      stalls = 0; np_stalls = 0; first_stall = -1;
      first_prod_cyc = -1; first_pop_cyc = -1; hold_err = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame from IDLE until frame_done is observed.
   // mr_mode: 0 = always ready, 1 = random, 2 = stalled for 60 cycles then random.
   task automatic run_frame(input bit sv_rand, input int mr_mode, input bit poke, output bit timed_out);
      bit poked_run = 1'b0, poked_drain = 1'b0;
      start = 1'b1; s_valid = 1'b0; m_ready = (mr_mode == 0);
      tick();
      timed_out = 1'b1;
      for (int n = 0; n < 8000; n++) begin
         start   = 1'b0;
         s_valid = sv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = (n < 60) ? 1'b0 : 1'($urandom_range(0, 1));
         endcase
         if (poke && !poked_run && fbeats >= 100) begin start = 1'b1; poked_run = 1'b1; end
         if (poke && !poked_drain && busy && fbeats == NB && !frame_done) begin
            start = 1'b1; poked_drain = 1'b1;
         end
         tick();
         if (fd_cnt > 0) begin timed_out = 1'b0; break; end
      end
      start = 1'b0; s_valid = 1'b0;
   endtask

   task automatic check_frame(input string nm, input int s, input bit timed_out);
      int mism = 0;
      n_total++;
      if (timed_out !== 1'b0) $display("FAIL %s_timeout: frame_done not seen within budget", nm);
      else n_pass++;
      n_total++;
      if (got_q.size() != NR) $display("FAIL %s_count: got %0d results, want %0d", nm, got_q.size(), NR);
      else n_pass++;
      for (int i = 0; i < NR; i++)
         if (i >= got_q.size() || got_q[i] !== exp_res[s][i]) mism++;
      n_total++;
      if (mism != 0) $display("FAIL %s_data: %0d mismatching results, want 0", nm, mism);
      else n_pass++;
      n_total++;
      if (beats != NB) $display("FAIL %s_beats: got %0d accepted beats, want %0d", nm, beats, NB);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      repeat (3) tick();
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else n_pass++;
      n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
      n_total++; if (m_data !== '0) $display("FAIL reset_m_data: got %h want 0", m_data); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
`ifdef POOL_CTRL_PERF_EN
      n_total++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); else n_pass++;
`endif
      rst_n = 1'b1;
      s_valid = 1'b1;
      tick();
      n_total++; if (s_ready !== 1'b0) $display("FAIL idle_s_ready: got %b want 0", s_ready); else n_pass++;
      s_valid = 1'b0;
   endtask

   task automatic test_full_frame();
      bit to;
      int s = (emu_cnt / NB) % 2;
      gen_frame(s);
      clear_mon();
      run_frame(1'b0, 0, 1'b0, to);
      repeat (5) tick();
      check_frame("full", s, to);
      n_total++; if (stalls != 0) $display("FAIL full_stalls: got %0d want 0", stalls); else n_pass++;
      n_total++; if (fd_cnt != 1) $display("FAIL full_frame_done_count: got %0d want 1", fd_cnt); else n_pass++;
      n_total++;
      if (fd_cyc - last_beat_cyc != 3) $display("FAIL full_done_latency: got %0d want 3", fd_cyc - last_beat_cyc);
      else n_pass++;
      n_total++;
      if (first_pop_cyc - first_prod_cyc != 2) $display("FAIL full_result_latency: got %0d want 2", first_pop_cyc - first_prod_cyc);
      else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL full_overflow: got %b want 0", overflow); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL full_busy_after: got %b want 0", busy); else n_pass++;
`ifdef POOL_CTRL_PERF_EN
      n_total++; if (stall_cycles !== 32'd0) $display("FAIL full_stall_cycles: got %0d want 0", stall_cycles); else n_pass++;
`endif
   endtask

   task automatic test_backpressure();
      bit to;
      int s = (emu_cnt / NB) % 2;
      int cnt = 0, exp_pos = -1;
      for (int k = 0; k < NB; k++)
         if ((k / W) % 2 == 1 && (k % W) % 2 == 1) begin
            cnt++;
            if (cnt == D + 1 && exp_pos < 0) exp_pos = k;
         end
      gen_frame(s);
      clear_mon();
      run_frame(1'b0, 2, 1'b0, to);
      repeat (3) tick();
      check_frame("bp", s, to);
      n_total++; if (first_stall != exp_pos) $display("FAIL bp_first_stall: got beat %0d want %0d", first_stall, exp_pos); else n_pass++;
      n_total++; if (np_stalls != 0) $display("FAIL bp_nonproducing_stall: got %0d want 0", np_stalls); else n_pass++;
      n_total++; if (hold_err != 0) $display("FAIL bp_hold: got %0d unstable heads want 0", hold_err); else n_pass++;
      n_total++; if (fd_cnt != 1) $display("FAIL bp_frame_done_count: got %0d want 1", fd_cnt); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow); else n_pass++;
`ifdef POOL_CTRL_PERF_EN
      n_total++;
      if (stall_cycles !== 32'(stalls) || stalls == 0) $display("FAIL bp_stall_cycles: got %0d want %0d (nonzero)", stall_cycles, stalls);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      bit to;
      logic [191:0] v;
      int m, s1, s2;
      s1 = (emu_cnt / NB) % 2;
      s2 = 1 - s1;
      gen_frame(s1);
      gen_frame(s2);
      clear_mon();
      run_frame(1'b1, 1, 1'b0, to);
      check_frame("b2b_first", s1, to);
      clear_mon();
      run_frame(1'b1, 1, 1'b0, to);
      repeat (3) tick();
      check_frame("b2b_second", s2, to);
      for (int ch = 0; ch < 6; ch++) begin
         m = pix[s2][0][ch];
         if (pix[s2][1][ch] > m)     m = pix[s2][1][ch];
         if (pix[s2][W][ch] > m)     m = pix[s2][W][ch];
         if (pix[s2][W + 1][ch] > m) m = pix[s2][W + 1][ch];
         v[ch*32 +: 32] = m;
      end
      n_total++;
      if (got_q.size() == 0 || got_q[0] !== v)
         $display("FAIL b2b_first_result: got %h want %h", (got_q.size() == 0) ? 192'd0 : got_q[0], v);
      else n_pass++;
      n_total++; if (fd_cnt != 1) $display("FAIL b2b_frame_done_count: got %0d want 1", fd_cnt); else n_pass++;
   endtask

   task automatic test_start_ignored();
      bit to;
      int s = (emu_cnt / NB) % 2;
      gen_frame(s);
      clear_mon();
      run_frame(1'b1, 0, 1'b1, to);
      repeat (6) tick();
      check_frame("ign", s, to);
      n_total++; if (fd_cnt != 1) $display("FAIL ign_frame_done_count: got %0d want 1", fd_cnt); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL ign_busy_after: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [191:0] d [6];
      int mism = 0;
      clear_mon();
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) d[i] = rand192();
      for (int i = 0; i < 4; i++) begin
         inj_data = d[i]; inj_pv = 1'b1;
         tick();
      end
      inj_pv = 1'b0;
      n_total++; if (m_data !== d[0]) $display("FAIL ovf_head: got %h want %h", m_data, d[0]); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else n_pass++;
      inj_data = d[4]; inj_pv = 1'b1; m_ready = 1'b1;
      tick();
      inj_pv = 1'b0; m_ready = 1'b0;
      n_total++; if (overflow !== 1'b0) $display("FAIL ovf_push_pop_full: got %b want 0", overflow); else n_pass++;
      n_total++; if (m_data !== d[1]) $display("FAIL ovf_head_after_pop: got %h want %h", m_data, d[1]); else n_pass++;
      inj_data = d[5]; inj_pv = 1'b1;
      tick();
      inj_pv = 1'b0;
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
      m_ready = 1'b1;
      repeat (6) tick();
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         if (i >= got_q.size() || got_q[i] !== d[i]) mism++;
      n_total++;
      if (got_q.size() != 5 || mism != 0) $display("FAIL ovf_contents: got %0d entries %0d wrong, want 5 entries 0 wrong", got_q.size(), mism);
      else n_pass++;
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
      n_total++; if (fd_cnt != 0) $display("FAIL ovf_idle_frame_done: got %0d want 0", fd_cnt); else n_pass++;
      rst_n = 1'b0;
      tick();
      n_total++; if (overflow !== 1'b0) $display("FAIL ovf_cleared_by_reset: got %b want 0", overflow); else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      bit to;
      int n;
      int s = (emu_cnt / NB) % 2;
      gen_frame(s);
      clear_mon();
      start = 1'b1; tick(); start = 1'b0;
      s_valid = 1'b1; m_ready = 1'b1;
      for (n = 0; n < 2000; n++) begin
         tick();
         if (fbeats >= 300) break;
      end
      n_total++; if (n >= 2000) $display("FAIL mid_reach_300: beat 300 not reached"); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL mid_async_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (m_valid !== 1'b0) $display("FAIL mid_async_m_valid: got %b want 0", m_valid); else n_pass++;
      tick();
      n_total++; if (s_ready !== 1'b0) $display("FAIL mid_s_ready: got %b want 0", s_ready); else n_pass++;
      n_total++; if (m_data !== '0) $display("FAIL mid_m_data: got %h want 0", m_data); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL mid_frame_done: got %b want 0", frame_done); else n_pass++;
      s_valid = 1'b0; m_ready = 1'b0;
      rst_n = 1'b1;
      tick();
      s = (emu_cnt / NB) % 2;
      gen_frame(s);
      clear_mon();
      run_frame(1'b1, 1, 1'b0, to);
      repeat (3) tick();
      check_frame("mid_restart", s, to);
      n_total++; if (fd_cnt != 1) $display("FAIL mid_frame_done_count: got %0d want 1", fd_cnt); else n_pass++;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_back_to_back();
      test_start_ignored();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
